// File: rtl/prbs31_chk_ctrl.sv
// PRBS31 receive checker: self-synchronising search/lock/count/done controller with error statistics.
// Optional bit-0 error injection input enabled by defining PRBS31_CHK_ERR_INJECT_EN.
module prbs31_chk_ctrl #(
  parameter int unsigned LOCK_GOOD  = 8,
  parameter int unsigned UNLOCK_BAD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] run_len,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
`ifdef PRBS31_CHK_ERR_INJECT_EN
  input  logic        inj_err,
`endif
  output logic [1:0]  state,
  output logic        locked,
  output logic        done,
  output logic [47:0] word_cnt,
  output logic [31:0] bit_err_cnt,
  output logic [15:0] lock_loss_cnt
);

  localparam int unsigned GW = $clog2(LOCK_GOOD + 1);
  localparam int unsigned BW = $clog2(UNLOCK_BAD + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t         st;
  logic [31:0]    expected;
  logic [GW-1:0]  good_run;
  logic [BW-1:0]  bad_run;
  logic [31:0]    run_len_q;

  // 32-step advance of x^31+x^28+1
  function automatic logic [31:0] prbs_next(input logic [31:0] w);
    logic [31:0] n;
    n[31:4] = w[30:3] ^ w[27:0];
    n[3:0]  = {w[2:0], w[30] ^ w[27]} ^ n[31:28];
    return n;
  endfunction

  logic [31:0]   cmp_data;
  logic [31:0]   diff;
  logic [5:0]    pop;
  logic [32:0]   err_sum;
  logic [47:0]   wc_inc;
  logic          match;
  logic [GW-1:0] good_n;
  logic [BW-1:0] bad_n;

  always_comb begin
    cmp_data = rx_data;
`ifdef PRBS31_CHK_ERR_INJECT_EN
    cmp_data = {rx_data[31:1], rx_data[0] ^ inj_err};
`endif
    diff    = cmp_data ^ expected;
    pop     = 6'($countones(diff));
    err_sum = {1'b0, bit_err_cnt} + 33'(pop);
    wc_inc  = word_cnt + 48'd1;
    match   = (diff == 32'd0) && (cmp_data != 32'd0);
    good_n  = match ? good_run + GW'(1) : '0;
    bad_n   = (diff != 32'd0) ? bad_run + BW'(1) : '0;
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= ST_IDLE;
      locked        <= 1'b0;
      done          <= 1'b0;
      word_cnt      <= '0;
      bit_err_cnt   <= '0;
      lock_loss_cnt <= '0;
      expected      <= '0;
      good_run      <= '0;
      bad_run       <= '0;
      run_len_q     <= '0;
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            st            <= ST_SEARCH;
            done          <= 1'b0;
            word_cnt      <= '0;
            bit_err_cnt   <= '0;
            lock_loss_cnt <= '0;
            good_run      <= '0;
            bad_run       <= '0;
            run_len_q     <= run_len;
          end
        end
        ST_SEARCH: begin
          if (stop) begin
            st   <= ST_DONE;
            done <= 1'b1;
          end else if (rx_valid) begin
            expected <= prbs_next(cmp_data);
            good_run <= good_n;
            if (good_n == GW'(LOCK_GOOD)) begin
              st      <= ST_LOCKED;
              locked  <= 1'b1;
              bad_run <= '0;
            end
          end
        end
        default: begin
          if (stop) begin
            st     <= ST_DONE;
            locked <= 1'b0;
            done   <= 1'b1;
          end else if (rx_valid) begin
            expected    <= prbs_next(expected);
            word_cnt    <= wc_inc;
            bit_err_cnt <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
            bad_run     <= bad_n;
            // run-length completion wins over an unlock on the same word
            if ((run_len_q != 32'd0) && (wc_inc == {16'd0, run_len_q})) begin
              st     <= ST_DONE;
              locked <= 1'b0;
              done   <= 1'b1;
            end else if (bad_n == BW'(UNLOCK_BAD)) begin
              st            <= ST_SEARCH;
              locked        <= 1'b0;
              good_run      <= '0;
              lock_loss_cnt <= (lock_loss_cnt == 16'hFFFF) ? 16'hFFFF : lock_loss_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
